// File: rtl/uart_pkg.sv
// Shared types and constants for the waveform UART receive path.
// Byte FSM state encodings live here so the bench and RTL agree.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int SAMPLE_W       = 14;
  localparam int WAVE_NUM_W     = 16;
  localparam int N_SAMPLES_DEF  = 500;

  typedef logic [2:0] rx_state_t;

  localparam rx_state_t ST_IDLE  = 3'd0;
  localparam rx_state_t ST_START = 3'd1;
  localparam rx_state_t ST_DATA  = 3'd2;
  localparam rx_state_t ST_STOP  = 3'd3;
  localparam rx_state_t ST_BREAK = 3'd4;

endpackage

// File: rtl/uart_byte_rx.sv
// Serial line synchroniser and 8N1 byte deserialiser.
// Emits registered byte_valid / frame_err pulses and an idle flag.
module uart_byte_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] byte_o,
  output logic                      byte_valid_o,
  output logic                      frame_err_o,
  output logic                      idle_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST = BW'(UART_DATA_BITS - 1);

  logic                      s1_q, s2_q;
  rx_state_t                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] sh_q, sh_d;
  logic                      bv_q, bv_d;
  logic                      fe_q, fe_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    sh_d    = sh_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!s2_q) state_d = ST_START;
      end
      ST_START: begin
        // Mid start bit: a high line here was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = s2_q ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          sh_d  = {s2_q, sh_q[UART_DATA_BITS-1:1]};
          bit_d = bit_q + BW'(1);
          if (bit_q == LAST) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (s2_q) begin
            bv_d    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        cnt_d = '0;
        if (s2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      s1_q    <= rx_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
    end
  end

  assign byte_o       = sh_q;
  assign byte_valid_o = bv_q;
  assign frame_err_o  = fe_q;
  assign idle_o       = (state_q == ST_IDLE);

endmodule

// File: rtl/uart_to_sample.sv
// Reassembles 3-byte UART records into ADC samples and a wave trailer.
// Partial records are dropped on framing errors or a long idle gap.
module uart_to_sample
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int N_SAMPLES    = N_SAMPLES_DEF,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  output logic [SAMPLE_W-1:0]   sample,
  output logic [7:0]            sample_index,
  output logic                  sample_valid,
  output logic                  seq_err,
  output logic [WAVE_NUM_W-1:0] wave_number,
  output logic                  wave_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int RW     = $clog2(N_SAMPLES + 1);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC);
  localparam logic [RW-1:0] REC_LAST = RW'(N_SAMPLES);
  localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

  logic [7:0] rx_byte;
  logic       bv, fe, rx_idle;

  uart_byte_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk         (clk),
    .reset       (reset),
    .rx_i        (rx),
    .byte_o      (rx_byte),
    .byte_valid_o(bv),
    .frame_err_o (fe),
    .idle_o      (rx_idle)
  );

  logic [RW-1:0]         rec_q, rec_d;
  logic [1:0]            slot_q, slot_d;
  logic [7:0]            hi_q, hi_d, lo_q, lo_d;
  logic [SAMPLE_W-1:0]   smp_q, smp_d;
  logic [7:0]            idx_q, idx_d;
  logic [WAVE_NUM_W-1:0] wn_q, wn_d;
  logic                  sv_q, sv_d, se_q, se_d, wv_q, wv_d;
  logic [TW-1:0]         to_q, to_d;
  logic [7:0]            exp_idx;
  logic                  waiting, timeout;

  assign busy    = (rec_q != '0) || (slot_q != '0);
  assign exp_idx = 8'(rec_q) + 8'd1;
  assign waiting = busy && rx_idle;
  assign timeout = waiting && (to_q == TO_LAST);

  always_comb begin
    rec_d  = rec_q;
    slot_d = slot_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    smp_d  = smp_q;
    idx_d  = idx_q;
    wn_d   = wn_q;
    sv_d   = 1'b0;
    se_d   = 1'b0;
    wv_d   = 1'b0;
    to_d   = '0;
    if (waiting && to_q != TO_LAST) to_d = to_q + TW'(1);
    else if (waiting)               to_d = to_q;
    if (fe) begin
      rec_d  = '0;
      slot_d = '0;
    end else if (bv) begin
      to_d = '0;
      unique case (slot_q)
        2'd0: begin
          hi_d   = rx_byte;
          slot_d = 2'd1;
        end
        2'd1: begin
          lo_d   = rx_byte;
          slot_d = 2'd2;
        end
        default: begin
          slot_d = '0;
          if (rec_q == REC_LAST) begin
            wn_d  = {hi_q, lo_q};
            wv_d  = 1'b1;
            rec_d = '0;
          end else begin
            smp_d = {hi_q[5:0], lo_q};
            idx_d = rx_byte;
            sv_d  = 1'b1;
            se_d  = (rx_byte != exp_idx);
            rec_d = rec_q + RW'(1);
          end
        end
      endcase
    end else if (timeout) begin
      rec_d  = '0;
      slot_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rec_q  <= '0;
      slot_q <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      smp_q  <= '0;
      idx_q  <= '0;
      wn_q   <= '0;
      sv_q   <= 1'b0;
      se_q   <= 1'b0;
      wv_q   <= 1'b0;
      to_q   <= '0;
    end else begin
      rec_q  <= rec_d;
      slot_q <= slot_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      smp_q  <= smp_d;
      idx_q  <= idx_d;
      wn_q   <= wn_d;
      sv_q   <= sv_d;
      se_q   <= se_d;
      wv_q   <= wv_d;
      to_q   <= to_d;
    end
  end

  assign sample       = smp_q;
  assign sample_index = idx_q;
  assign sample_valid = sv_q;
  assign seq_err      = se_q;
  assign wave_number  = wn_q;
  assign wave_valid   = wv_q;
  assign frame_err    = fe;

endmodule

// File: tb/tb_uart_to_sample.sv
// Bench for uart_to_sample: record table plus hand-built corner cases.
// Output events are matched against a queue of expected events.
module tb_uart_to_sample;

  localparam int CPB = 16;
  localparam int NS  = 4;
  localparam int TOB = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic [13:0] sample;
  logic [7:0]  sample_index;
  logic        sample_valid, seq_err, wave_valid, frame_err, busy;
  logic [15:0] wave_number;

  always #5 clk = ~clk;

  uart_to_sample #(
    .CLKS_PER_BIT(CPB),
    .N_SAMPLES   (NS),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .sample      (sample),
    .sample_index(sample_index),
    .sample_valid(sample_valid),
    .seq_err     (seq_err),
    .wave_number (wave_number),
    .wave_valid  (wave_valid),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [13:0] s;
    logic [7:0]  idx;
    logic        se;
    logic [15:0] wn;
  } ev_t;

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         stops;
    ev_t        exp;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  ev_t  q[$];
  ev_t  mon_a, mon_e;
  int   bv_cnt = 0;
  logic [7:0] last_byte = 8'h00;
  vec_t tbl[8];

  function automatic ev_t mk_ev(input logic [1:0] k, input logic [13:0] s,
                                input logic [7:0] i, input logic se,
                                input logic [15:0] wn);
    ev_t e;
    e.kind = k;
    e.s    = s;
    e.idx  = i;
    e.se   = se;
    e.wn   = wn;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (sample_valid || wave_valid || frame_err)) begin
      if (frame_err)
        mon_a = mk_ev(2'd2, 14'h0, 8'h0, 1'b0, 16'h0);
      else if (wave_valid)
        mon_a = mk_ev(2'd1, 14'h0, 8'h0, 1'b0, wave_number);
      else
        mon_a = mk_ev(2'd0, sample, sample_index, seq_err, 16'h0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: got %h expected none", mon_a);
      end else begin
        mon_e = q.pop_front();
        chk("event", 64'(mon_a), 64'(mon_e));
      end
    end
    if (dut.u_byte.byte_valid_o) begin
      bv_cnt++;
      last_byte = dut.u_byte.byte_o;
    end
  end

  task automatic bit_t(input logic v);
    rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int stops,
                           input logic stop_v);
    bit_t(1'b0);
    for (int i = 0; i < 8; i++) bit_t(b[i]);
    bit_t(stop_v);
    if (!stop_v) bit_t(1'b1);
    for (int i = 1; i < stops; i++) bit_t(1'b1);
  endtask

  task automatic send_rec(input logic [7:0] b0, b1, b2, input int stops);
    send_byte(b0, stops, 1'b1);
    send_byte(b1, stops, 1'b1);
    send_byte(b2, stops, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sample"}, 64'(sample), 64'h0);
    chk({tag, "_index"}, 64'(sample_index), 64'h0);
    chk({tag, "_wave"}, 64'(wave_number), 64'h0);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_pulses"},
        64'({sample_valid, seq_err, wave_valid, frame_err}), 64'h0);
  endtask

  initial begin
    int bv0;
    tbl[0] = '{8'h1A, 8'hBC, 8'h01, 3, mk_ev(0, 14'h1ABC, 8'h01, 0, 0)};
    tbl[1] = '{8'hFF, 8'h00, 8'h02, 3, mk_ev(0, 14'h3F00, 8'h02, 0, 0)};
    tbl[2] = '{8'hC5, 8'h5A, 8'h03, 3, mk_ev(0, 14'h055A, 8'h03, 0, 0)};
    tbl[3] = '{8'h00, 8'h7E, 8'h04, 3, mk_ev(0, 14'h007E, 8'h04, 0, 0)};
    tbl[4] = '{8'h12, 8'h34, 8'h00, 3, mk_ev(1, 14'h0, 8'h0, 0, 16'h1234)};
    tbl[5] = '{8'h11, 8'h22, 8'h01, 1, mk_ev(0, 14'h1122, 8'h01, 0, 0)};
    tbl[6] = '{8'h33, 8'h44, 8'h05, 1, mk_ev(0, 14'h3344, 8'h05, 1, 0)};
    tbl[7] = '{8'h05, 8'h66, 8'h03, 1, mk_ev(0, 14'h0566, 8'h03, 0, 0)};

    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    repeat (CPB) @(negedge clk);

    // Lone byte: internal byte path only, no record output yet.
    send_byte(8'hA5, 1, 1'b1);
    chk("byte_valid_cycles", 64'(bv_cnt), 64'd1);
    chk("byte_value", 64'(last_byte), 64'hA5);
    chk("byte_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (CPB) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      q.push_back(tbl[i].exp);
      send_rec(tbl[i].b0, tbl[i].b1, tbl[i].b2, tbl[i].stops);
      if (i == 4) chk("wave_busy_low", 64'(busy), 64'd0);
    end
    chk("seq_busy", 64'(busy), 64'd1);

    // Reset in the middle of a data bit.
    bit_t(1'b0);
    bit_t(1'b1);
    bit_t(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midreset");
    reset = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    q.push_back(mk_ev(2, 14'h0, 8'h0, 0, 0));
    send_byte(8'h10, 1, 1'b1);
    send_byte(8'h20, 1, 1'b0);
    chk("frame_busy", 64'(busy), 64'd0);

    bv0 = bv_cnt;
    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    chk("glitch_idle", 64'(dut.u_byte.idle_o), 64'd1);
    chk("glitch_no_byte", 64'(bv_cnt - bv0), 64'd0);

    q.push_back(mk_ev(0, 14'h0102, 8'h01, 0, 0));
    send_rec(8'h01, 8'h02, 8'h01, 1);

    send_byte(8'h2A, 1, 1'b1);
    chk("to_busy_start", 64'(busy), 64'd1);
    repeat (60 * CPB) @(negedge clk);
    chk("to_busy_before", 64'(busy), 64'd1);
    repeat (5 * CPB) @(negedge clk);
    chk("to_busy_after", 64'(busy), 64'd0);
    q.push_back(mk_ev(0, 14'h0708, 8'h01, 0, 0));
    send_rec(8'h07, 8'h08, 8'h01, 1);

    repeat (2 * CPB) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
